// File: rtl/befehl_holer.sv
// befehl_holer: instruction-fetch stage between the program counter and the decoder.
//   Reads one word per instruction at the current PC, holds it for the decoder
//   and pulses the program counter to advance. At most one read is outstanding.
//   Optional bus timeout: define BEFEHL_HOLER_TIMEOUT_EN.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   pc_i                        current PC (AktuellerPC)
//   pc_takt_o                   one-cycle advance pulse to the PC (TaktSignal)
//   speicher_adresse_o          registered read address
//   speicher_lesen_o            read request valid
//   speicher_bereit_i           memory accepts the request
//   speicher_daten_i            read data
//   speicher_daten_gueltig_i    read data valid, one cycle per accepted request
//   befehl_o, befehl_gueltig_o  held instruction and its valid flag
//   befehl_annehmen_i           decoder accepts the instruction
//   verwerfen_i                 flush, asserted when the jump logic writes the PC
//   fehler_o                    sticky bus timeout (0 without the timeout build)
module befehl_holer #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  pc_takt_o,
    output logic [ADDR_WIDTH-1:0] speicher_adresse_o,
    output logic                  speicher_lesen_o,
    input  logic                  speicher_bereit_i,
    input  logic [DATA_WIDTH-1:0] speicher_daten_i,
    input  logic                  speicher_daten_gueltig_i,
    output logic [DATA_WIDTH-1:0] befehl_o,
    output logic                  befehl_gueltig_o,
    input  logic                  befehl_annehmen_i,
    input  logic                  verwerfen_i,
    output logic                  fehler_o
);
    typedef enum logic [1:0] {LEERLAUF, ANFRAGE, WARTEN, GUELTIG} state_e;

    state_e                  state_q;
    logic                    discard_q;
    logic                    pc_takt_q;
    logic                    lesen_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   befehl_q;
    logic                    gueltig_q;
    logic                    stall;

`ifdef BEFEHL_HOLER_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          fehler_q;
    logic          timeout;
    // cnt_q counts completed WARTEN cycles; the last one without data expires.
    assign timeout  = (state_q == WARTEN) && !speicher_daten_gueltig_i &&
                      (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign stall    = fehler_q;
    assign fehler_o = fehler_q;
`else
    assign stall    = 1'b0;
    // Timeout limit only matters in the timeout build.
    assign fehler_o = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LEERLAUF;
            discard_q <= 1'b0;
            pc_takt_q <= 1'b0;
            lesen_q   <= 1'b0;
            adr_q     <= '0;
            befehl_q  <= '0;
            gueltig_q <= 1'b0;
`ifdef BEFEHL_HOLER_TIMEOUT_EN
            cnt_q     <= '0;
            fehler_q  <= 1'b0;
`endif
        end else begin
            pc_takt_q <= 1'b0;
            case (state_q)
                // Holding one cycle on a flush lets the latch see the rewritten PC.
                LEERLAUF: if (!verwerfen_i && !stall) begin
                    adr_q   <= pc_i;
                    lesen_q <= 1'b1;
                    state_q <= ANFRAGE;
                end
                // The request is never withdrawn; a flush only marks its response.
                ANFRAGE: begin
                    if (verwerfen_i) discard_q <= 1'b1;
                    if (speicher_bereit_i) begin
                        lesen_q <= 1'b0;
                        state_q <= WARTEN;
                    end
                end
                WARTEN: if (speicher_daten_gueltig_i) begin
                    discard_q <= 1'b0;
                    if (discard_q || verwerfen_i) begin
                        state_q <= LEERLAUF;
                    end else begin
                        befehl_q  <= speicher_daten_i;
                        gueltig_q <= 1'b1;
                        pc_takt_q <= 1'b1;
                        state_q   <= GUELTIG;
                    end
                end
`ifdef BEFEHL_HOLER_TIMEOUT_EN
                else if (timeout) begin
                    fehler_q  <= 1'b1;
                    discard_q <= 1'b0;
                    state_q   <= LEERLAUF;
                end
`endif
                else if (verwerfen_i) begin
                    discard_q <= 1'b1;
                end
                GUELTIG: if (verwerfen_i || befehl_annehmen_i) begin
                    gueltig_q <= 1'b0;
                    state_q   <= LEERLAUF;
                end
                default: state_q <= LEERLAUF;
            endcase
`ifdef BEFEHL_HOLER_TIMEOUT_EN
            cnt_q <= (state_q == WARTEN && !speicher_daten_gueltig_i && !timeout) ? cnt_q + 1'b1 : '0;
`endif
        end
    end

    assign pc_takt_o          = pc_takt_q;
    assign speicher_lesen_o   = lesen_q;
    assign speicher_adresse_o = adr_q;
    assign befehl_o           = befehl_q;
    assign befehl_gueltig_o   = gueltig_q;
endmodule

// File: tb/tb_befehl_holer.sv
// tb_befehl_holer: directed, table-driven bench for befehl_holer.
module tb_befehl_holer;
    localparam int AW = 26;
    localparam int DW = 32;
`ifdef BEFEHL_HOLER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          takt;
    logic [AW-1:0] adr;
    logic          lesen;
    logic          rdy = 1'b0;
    logic [DW-1:0] dat = '0;
    logic          dv = 1'b0;
    logic [DW-1:0] bef;
    logic          bg;
    logic          ann = 1'b0;
    logic          vw = 1'b0;
    logic          fehler;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    befehl_holer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .pc_takt_o(takt),
        .speicher_adresse_o(adr), .speicher_lesen_o(lesen), .speicher_bereit_i(rdy),
        .speicher_daten_i(dat), .speicher_daten_gueltig_i(dv),
        .befehl_o(bef), .befehl_gueltig_o(bg), .befehl_annehmen_i(ann),
        .verwerfen_i(vw), .fehler_o(fehler)
    );

    // One record per clock cycle: inputs driven during the cycle and the
    // registered outputs expected during that same cycle.
    typedef struct {
        logic [AW-1:0] pc;
        logic          rdy, dv;
        logic [DW-1:0] dat;
        logic          ann, vw;
        logic          takt, lesen;
        logic [AW-1:0] adr;
        logic [DW-1:0] bef;
        logic          bg;
    } vec_t;

    vec_t v[36];

    task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, exp);
        end
    endtask

    task automatic setv(input int i, input logic [AW-1:0] p, input logic r, input logic d,
                        input logic [DW-1:0] da, input logic a, input logic w,
                        input logic et, input logic el, input logic [AW-1:0] ea,
                        input logic [DW-1:0] eb, input logic eg);
        v[i] = '{pc: p, rdy: r, dv: d, dat: da, ann: a, vw: w,
                 takt: et, lesen: el, adr: ea, bef: eb, bg: eg};
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, ".takt"},  {31'd0, takt},  0);
        chk({n, ".lesen"}, {31'd0, lesen}, 0);
        chk({n, ".adr"},   {6'd0, adr},    0);
        chk({n, ".bef"},   bef,            0);
        chk({n, ".bg"},    {31'd0, bg},    0);
        chk({n, ".fehler"},{31'd0, fehler},0);
    endtask

    initial begin
        //        pc     rdy dv data          ann vw  takt les adr    befehl        bg
        setv( 0, 'h10,  1, 0, 0,             0, 0,  0, 0, 'h0,   32'h0,        0);
        setv( 1, 'h10,  1, 0, 0,             0, 0,  0, 1, 'h10,  32'h0,        0);
        setv( 2, 'h10,  1, 1, 32'hDEADBEEF,  0, 0,  0, 0, 'h10,  32'h0,        0);
        setv( 3, 'h10,  1, 0, 0,             0, 0,  1, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 4, 'h11,  1, 0, 0,             0, 0,  0, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 5, 'h11,  1, 0, 0,             0, 0,  0, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 6, 'h11,  1, 1, 32'hBAD0BAD0,  0, 0,  0, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 7, 'h11,  1, 0, 0,             0, 0,  0, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 8, 'h11,  1, 0, 0,             1, 0,  0, 0, 'h10,  32'hDEADBEEF, 1);
        setv( 9, 'h11,  0, 0, 0,             0, 0,  0, 0, 'h10,  32'hDEADBEEF, 0);
        setv(10, 'h11,  0, 0, 0,             0, 0,  0, 1, 'h11,  32'hDEADBEEF, 0);
        setv(11, 'h11,  0, 1, 32'h0BAD0BAD,  0, 0,  0, 1, 'h11,  32'hDEADBEEF, 0);
        setv(12, 'h11,  0, 0, 0,             0, 0,  0, 1, 'h11,  32'hDEADBEEF, 0);
        setv(13, 'h11,  1, 0, 0,             0, 0,  0, 1, 'h11,  32'hDEADBEEF, 0);
        setv(14, 'h11,  1, 0, 0,             0, 0,  0, 0, 'h11,  32'hDEADBEEF, 0);
        setv(15, 'h11,  0, 1, 32'hCAFEF00D,  0, 0,  0, 0, 'h11,  32'hDEADBEEF, 0);
        setv(16, 'h11,  0, 0, 0,             1, 0,  1, 0, 'h11,  32'hCAFEF00D, 1);
        setv(17, 'h12,  0, 0, 0,             0, 0,  0, 0, 'h11,  32'hCAFEF00D, 0);
        setv(18, 'h12,  1, 0, 0,             0, 0,  0, 1, 'h12,  32'hCAFEF00D, 0);
        setv(19, 'h12,  0, 0, 0,             0, 1,  0, 0, 'h12,  32'hCAFEF00D, 0);
        setv(20, 'h200, 0, 1, 32'h12345678,  0, 0,  0, 0, 'h12,  32'hCAFEF00D, 0);
        setv(21, 'h200, 0, 0, 0,             0, 0,  0, 0, 'h12,  32'hCAFEF00D, 0);
        setv(22, 'h200, 1, 0, 0,             0, 0,  0, 1, 'h200, 32'hCAFEF00D, 0);
        setv(23, 'h200, 0, 1, 32'h11112222,  0, 0,  0, 0, 'h200, 32'hCAFEF00D, 0);
        setv(24, 'h200, 0, 0, 0,             1, 1,  1, 0, 'h200, 32'h11112222, 1);
        setv(25, 'h300, 0, 0, 0,             0, 0,  0, 0, 'h200, 32'h11112222, 0);
        setv(26, 'h300, 0, 0, 0,             0, 1,  0, 1, 'h300, 32'h11112222, 0);
        setv(27, 'h300, 1, 0, 0,             0, 0,  0, 1, 'h300, 32'h11112222, 0);
        setv(28, 'h300, 0, 1, 32'h55556666,  0, 0,  0, 0, 'h300, 32'h11112222, 0);
        setv(29, 'h300, 0, 1, 32'h5A5A5A5A,  0, 0,  0, 0, 'h300, 32'h11112222, 0);
        setv(30, 'h300, 1, 0, 0,             0, 0,  0, 1, 'h300, 32'h11112222, 0);
        setv(31, 'h300, 0, 1, 32'h77778888,  0, 1,  0, 0, 'h300, 32'h11112222, 0);
        setv(32, 'h301, 0, 0, 0,             0, 0,  0, 0, 'h300, 32'h11112222, 0);
        setv(33, 'h301, 1, 0, 0,             0, 0,  0, 1, 'h301, 32'h11112222, 0);
        setv(34, 'h301, 0, 1, 32'h9999AAAA,  0, 0,  0, 0, 'h301, 32'h11112222, 0);
        setv(35, 'h301, 0, 0, 0,             0, 0,  1, 0, 'h301, 32'h9999AAAA, 1);

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            pc = v[i].pc; rdy = v[i].rdy; dv = v[i].dv; dat = v[i].dat;
            ann = v[i].ann; vw = v[i].vw;
            chk($sformatf("c%0d.takt", i),  {31'd0, takt},  {31'd0, v[i].takt});
            chk($sformatf("c%0d.lesen", i), {31'd0, lesen}, {31'd0, v[i].lesen});
            chk($sformatf("c%0d.adr", i),   {6'd0, adr},    {6'd0, v[i].adr});
            chk($sformatf("c%0d.bef", i),   bef,            v[i].bef);
            chk($sformatf("c%0d.bg", i),    {31'd0, bg},    {31'd0, v[i].bg});
            chk($sformatf("c%0d.fehler", i),{31'd0, fehler},0);
            @(negedge clk);
        end

        // Reset pulsed while a read is outstanding; it acts without a clock edge.
        pc = 'h40; ann = 1'b1; rdy = 1'b0; dv = 1'b0; vw = 1'b0;
        @(negedge clk);
        ann = 1'b0;
        @(negedge clk);
        chk("rst.req_lesen", {31'd0, lesen}, 1);
        chk("rst.req_adr", {6'd0, adr}, 'h40);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("rst.warten_lesen", {31'd0, lesen}, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        pc = 'h55;
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.lesen", {31'd0, lesen}, 1);
        chk("post_rst.adr", {6'd0, adr}, 'h55);
        chk("post_rst.bg", {31'd0, bg}, 0);

`ifdef BEFEHL_HOLER_TIMEOUT_EN
        // No response after the handshake: Fehler after TO WARTEN cycles, then stall.
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("to.before", {31'd0, fehler}, 0);
        @(negedge clk);
        chk("to.fehler", {31'd0, fehler}, 1);
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("to.stall%0d.lesen", k), {31'd0, lesen}, 0);
            chk($sformatf("to.stall%0d.fehler", k), {31'd0, fehler}, 1);
        end
        rst_n = 1'b0;
        #1 chk("to.rst_fehler", {31'd0, fehler}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/befehl_holer.md
Name: befehl_holer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues one read per instruction on the instruction-memory request/response interface, holds the returned word for the decoder, and pulses the program counter's TaktSignal to advance it.
- At most one memory read is outstanding at any time.
- Supports a flush input so that a taken jump discards in-flight or held instructions.

Parameters:
- ADDR_WIDTH, 26, PC / word-address width; matches the program counter output.
- DATA_WIDTH, 32, instruction word width.
- TIMEOUT_CYCLES, 255, WARTEN cycles before a bus error is raised. Used only with the optional feature.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PC  in  ADDR_WIDTH  current PC from the program counter (AktuellerPC).
- PCTakt  out  1  one-cycle advance pulse to the program counter's TaktSignal.
- SpeicherAdresse  out  ADDR_WIDTH  read address, registered.
- SpeicherLesen  out  1  read request valid.
- SpeicherBereit  in  1  memory accepts the request.
- SpeicherDaten  in  DATA_WIDTH  read data.
- SpeicherDatenGueltig  in  1  read data valid; one cycle per accepted request.
- Befehl  out  DATA_WIDTH  held instruction.
- BefehlGueltig  out  1  Befehl valid for the decoder.
- BefehlAnnehmen  in  1  decoder accepts Befehl.
- Verwerfen  in  1  flush; asserted in the same cycle the jump logic writes the PC.
- Fehler  out  1  sticky bus timeout. Tied 0 without the optional feature.

Behaviour:
- Reset asserted, at any time:
  - State becomes LEERLAUF and the discard flag clears.
  - All outputs clear: PCTakt=0, SpeicherLesen=0, SpeicherAdresse=0, Befehl=0, BefehlGueltig=0, Fehler=0.
- States and transitions:
  - LEERLAUF: unless Verwerfen, go to ANFRAGE next edge and latch SpeicherAdresse<=PC at that edge. With Verwerfen, stay one more cycle so the latch sees the updated PC.
  - ANFRAGE: SpeicherLesen=1. Address and request are held stable until SpeicherBereit. Once SpeicherLesen is up it is never withdrawn, including on Verwerfen. On SpeicherBereit, go to WARTEN; SpeicherLesen drops the next cycle.
  - WARTEN: on SpeicherDatenGueltig with the discard flag clear:
    - Befehl<=SpeicherDaten, BefehlGueltig<=1.
    - PCTakt=1 for exactly the next cycle.
    - Go to GUELTIG.
  - WARTEN: on SpeicherDatenGueltig with the discard flag set: clear the flag, no capture, no PCTakt, go to LEERLAUF.
  - GUELTIG: Befehl and BefehlGueltig are held. On BefehlAnnehmen, BefehlGueltig<=0 and go to LEERLAUF.
- Throughput: one instruction per 4 cycles minimum; capture to next request is 2 cycles.
- PC timing: the program counter updates at the edge ending the PCTakt cycle. The LEERLAUF latch always falls at least one edge later, so the next address is PC+1.
- Verwerfen:
  - In ANFRAGE or WARTEN: set the discard flag; the request completes normally and its response is dropped.
  - In GUELTIG: BefehlGueltig<=0, go to LEERLAUF. Verwerfen wins over a simultaneous BefehlAnnehmen.
  - Together with SpeicherDatenGueltig in WARTEN: the response is dropped and the discard flag is not left set.
  - An already-issued PCTakt pulse is not retracted; the program counter's write priority resolves the overlap.
- Spurious SpeicherDatenGueltig outside WARTEN: ignored.
- SpeicherBereit outside ANFRAGE: ignored.
- PCTakt is never high for two consecutive cycles.

Optional Feature:
- Macro: BEFEHL_HOLER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs while in WARTEN and clears on leaving WARTEN.
  - Reaching TIMEOUT_CYCLES sets Fehler (sticky until Reset), drops the outstanding response, and goes to LEERLAUF.
  - Fetching then stalls in LEERLAUF while Fehler=1.
- Undefined: no counter; WARTEN waits indefinitely; Fehler is constant 0.

Test Plan:
- Reset release, PC=0x10, SpeicherBereit=1, data 0xDEADBEEF with 1-cycle latency -> SpeicherAdresse=0x10, Befehl=0xDEADBEEF, BefehlGueltig=1, single PCTakt pulse.
- Decoder holds BefehlAnnehmen=0 for 5 cycles -> Befehl and BefehlGueltig stable, no new request. Then accept -> next request address 0x11.
- SpeicherBereit low for 3 cycles -> SpeicherLesen and SpeicherAdresse held constant all 3 cycles, then one handshake.
- Verwerfen in WARTEN, PC rewritten to 0x200, response 0x12345678 -> no capture, no PCTakt, next request address 0x200.
- Verwerfen and BefehlAnnehmen together in GUELTIG; also Reset pulsed during WARTEN -> BefehlGueltig=0. After Reset, every output is 0 and the first request uses the current PC.
- With BEFEHL_HOLER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> Fehler=1 after 8 WARTEN cycles, no further SpeicherLesen until Reset.
